// File: rtl/bit_serializer_pkg.sv
// bit_serializer_pkg: shared types and defaults for the bit serializer.
// Holds the two-state FSM enum and the default parallel word width.
package bit_serializer_pkg;
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
    localparam int DEFAULT_DATA_W = 8;
endpackage

// File: rtl/ser_fifo2.sv
// ser_fifo2: two-entry in-order word buffer.
// Ports: clk_i/reset_i (sync, active-high), push_i+data_i write, pop_i read,
// data_o shows the head entry, full_o/empty_o report occupancy.
// A push when full or a pop when empty is ignored, so the buffer never
// overflows or underflows; push and pop on one edge both take effect.
module ser_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    logic [DATA_W-1:0] mem_q [2];
    logic [DATA_W-1:0] mem_d [2];
    logic              wr_q, wr_d, rd_q, rd_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign full_o  = cnt_q == 2'd2;
    assign empty_o = cnt_q == 2'd0;
    assign data_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_q] = data_i;
        wr_d  = wr_q ^ do_push;
        rd_d  = rd_q ^ do_pop;
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-word to serial-bit converter with a 2-word buffer.
// Ports: clk_i/reset_i (sync, active-high); word_i/word_valid_i/word_ready_o
// accept words; data_o/bit_valid_o/last_o carry the serial stream (data_o is
// 0 while idle); busy_o is high while shifting or while a word is buffered.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              word_valid_i,
    output logic              word_ready_o,
    output logic              data_o,
    output logic              bit_valid_o,
    output logic              last_o,
    output logic              busy_o
);
    localparam int            CW       = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] sreg_q, sreg_d, head;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              data_q, data_d;
    logic              full, empty, push, pop, word_end;

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w << 1 : w >> 1;
    endfunction

    assign word_ready_o = !full;
    assign push         = word_valid_i && !full && !reset_i;
    // A word boundary is either idle or the final bit on show; a waiting
    // word is popped right here so consecutive words have no gap cycle.
    assign word_end     = state_q == IDLE || cnt_q == LAST_IDX;
    assign pop          = word_end && !empty;

    ser_fifo2 #(.DATA_W(DATA_W)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .data_i  (word_i),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // The first bit goes straight into the output flop on load; sreg keeps
    // only the bits still to come, pre-shifted so its edge bit is next.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        if (pop) begin
            state_d = SHIFT;
            sreg_d  = advance(head);
            data_d  = first_bit(head);
            cnt_d   = '0;
        end else if (word_end) begin
            state_d = IDLE;
            data_d  = 1'b0;
        end else begin
            sreg_d  = advance(sreg_q);
            data_d  = first_bit(sreg_q);
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            data_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign data_o      = data_q;
    assign bit_valid_o = state_q == SHIFT;
    assign last_o      = bit_valid_o && cnt_q == LAST_IDX;
    assign busy_o      = bit_valid_o || !empty;
endmodule

// File: tb/tb_bit_serializer.sv
// tb_bit_serializer: randomized and directed checks of bit_serializer (MSB and LSB first) against a word-level model.
module tb_bit_serializer;
    logic       clk_i = 1'b0;
    logic       reset_i = 1'b1;
    logic [7:0] word_i = '0;
    logic       word_valid_i = 1'b0;
    logic       rdy_m, dat_m, val_m, lst_m, bsy_m;
    logic       rdy_l, dat_l, val_l, lst_l, bsy_l;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] mbuf[$];
    logic [7:0] cw;
    int         idx;
    bit         act;

    int         vcnt, lcnt, run, maxrun;
    logic [7:0] capm, capl;
    bit         stream[$];
    bit         acc;

    always #5 clk_i = ~clk_i;

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(rdy_m), .data_o(dat_m), .bit_valid_o(val_m), .last_o(lst_m), .busy_o(bsy_m)
    );

    bit_serializer #(.DATA_W(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk_i), .reset_i(reset_i), .word_i(word_i), .word_valid_i(word_valid_i),
        .word_ready_o(rdy_l), .data_o(dat_l), .bit_valid_o(val_l), .last_o(lst_l), .busy_o(bsy_l)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic clear_caps();
        vcnt = 0; lcnt = 0; run = 0; maxrun = 0; capm = '0; capl = '0;
        stream.delete();
    endtask

    // One clock: drive inputs, advance the word-level model at the edge,
    // then compare every output of both instances on the falling edge.
    task automatic step(input logic r, input logic v, input logic [7:0] w, output bit accepted);
        reset_i = r; word_valid_i = v; word_i = w;
        accepted = v && !r && mbuf.size() < 2;
        @(posedge clk_i);
        if (r) begin
            mbuf.delete(); act = 0; idx = 0;
        end else begin
            if ((!act || idx == 7) && mbuf.size() > 0) begin
                cw = mbuf.pop_front(); idx = 0; act = 1;
            end else if (act && idx == 7) act = 0;
            else if (act) idx++;
            if (accepted) mbuf.push_back(w);
        end
        @(negedge clk_i);
        chk("ready_m", rdy_m, mbuf.size() < 2);
        chk("ready_l", rdy_l, mbuf.size() < 2);
        chk("valid_m", val_m, act);
        chk("valid_l", val_l, act);
        chk("data_m", dat_m, act ? cw[7-idx] : 1'b0);
        chk("data_l", dat_l, act ? cw[idx] : 1'b0);
        chk("last_m", lst_m, act && idx == 7);
        chk("last_l", lst_l, act && idx == 7);
        chk("busy_m", bsy_m, act || mbuf.size() > 0);
        chk("busy_l", bsy_l, act || mbuf.size() > 0);
        if (val_m) begin
            vcnt++; run++;
            capm = {capm[6:0], dat_m};
            capl = {dat_l, capl[7:1]};
            stream.push_back(dat_m);
            if (run > maxrun) maxrun = run;
        end else run = 0;
        if (lst_m) lcnt++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, a);
    endtask

    task automatic send(input logic [7:0] w);
        bit a;
        a = 0;
        for (int i = 0; i < 40 && !a; i++) step(1'b0, 1'b1, w, a);
        chk("send_accept", a, 1'b1);
    endtask

    initial begin
        logic [7:0] words[5];
        logic [7:0] cw6;
        int pairs_s, pairs_w;
        act = 0; idx = 0; cw = '0;
        clear_caps();
        step(1'b1, 1'b1, 8'h55, acc);
        step(1'b1, 1'b0, 8'h00, acc);

        clear_caps();
        send(8'hA5);
        idle(12);
        chk("a5_msb_seq", capm, 8'hA5);
        chk("a5_lsb_seq", capl, 8'hA5);
        chk("a5_valid_cycles", vcnt, 8);
        chk("a5_last_count", lcnt, 1);

        clear_caps();
        send(8'hFF); send(8'h00); send(8'hC3);
        idle(30);
        chk("b2b_bits", vcnt, 24);
        chk("b2b_run", maxrun, 24);
        chk("b2b_lasts", lcnt, 3);

        clear_caps();
        for (int i = 0; i < 5; i++) words[i] = 8'($urandom);
        for (int i = 0; i < 5; i++) send(words[i]);
        idle(50);
        chk("bp_bits", vcnt, 40);
        chk("bp_lasts", lcnt, 5);

        clear_caps();
        send(8'hF0); send(8'h3C);
        for (int i = 0; i < 20 && vcnt < 3; i++) step(1'b0, 1'b0, 8'h00, acc);
        chk("rst_bits_before", vcnt, 3);
        step(1'b1, 1'b1, 8'h77, acc);
        idle(20);
        chk("rst_bits_after", vcnt, 3);

        clear_caps();
        cw6 = 8'b0110_1100;
        send(cw6);
        idle(12);
        pairs_s = 0; pairs_w = 0;
        for (int i = 0; i + 1 < stream.size(); i++) if (stream[i] && stream[i+1]) pairs_s++;
        for (int i = 7; i > 0; i--) if (cw6[i] && cw6[i-1]) pairs_w++;
        chk("chain_len", stream.size(), 8);
        chk("chain_pairs", pairs_s, pairs_w);

        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 59) == 0, $urandom_range(0, 9) < 6, 8'($urandom), acc);
        idle(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
